// File: rtl/stepper_move_ctrl.sv
// Move sequencer for the 2-phase stepper driver: accepts a move command, issues step pulses
// with a linear accel/decel ramp, and tracks the signed absolute position.
module stepper_move_ctrl #(
    parameter int unsigned START_PERIOD = 100,
    parameter int unsigned MIN_PERIOD   = 20,
    parameter int unsigned ACCEL_DEC    = 10,
    parameter int unsigned PULSE_WIDTH  = 8,
    parameter int unsigned DIR_SETUP    = 16,
    parameter int unsigned HOLD_CYCLES  = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [15:0]        cmd_steps,
    input  logic               cmd_dir,
    input  logic [15:0]        cmd_period_min,
    input  logic               abort,
    output logic               rotate_pulse,
    output logic               direction,
    output logic               module_enable,
    output logic               busy,
    output logic               done,
    output logic signed [31:0] position
);

    localparam logic [15:0] START_P    = 16'(START_PERIOD);
    localparam logic [15:0] MIN_P      = 16'(MIN_PERIOD);
    localparam logic [15:0] ACC        = 16'(ACCEL_DEC);
    localparam logic [15:0] PW         = 16'(PULSE_WIDTH);
    localparam logic [15:0] SETUP_LAST = 16'(DIR_SETUP - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, RUN, HOLD} state_t;

    state_t      state, state_nxt;
    logic [15:0] tick, rem, cur, ramp_cnt, period_min;
    logic        abort_seen;

    logic        accept, setup_end, interval_end, run_stop, step_start, hold_end;
    logic [15:0] clamped, cur_nxt, ramp_nxt;
    logic [16:0] cur_up;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (accept && cmd_steps != '0) state_nxt = SETUP;
            SETUP: if (setup_end)                 state_nxt = RUN;
            RUN:   if (run_stop)                  state_nxt = HOLD;
            HOLD:  if (hold_end)                  state_nxt = IDLE;
            default:                              state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready    = (state == IDLE);
        busy         = (state != IDLE);
        accept       = cmd_ready && cmd_valid;
        setup_end    = (state == SETUP) && (tick == SETUP_LAST);
        interval_end = (state == RUN) && (tick == cur);
        // rem counts steps not yet started, so zero here means the last step's interval just ended
        run_stop     = interval_end && (rem == '0 || abort_seen || abort);
        step_start   = setup_end || (interval_end && !run_stop);
        hold_end     = (state == HOLD) && (tick == HOLD_LAST);
    end

    always_comb begin
        if (cmd_period_min < MIN_P)        clamped = MIN_P;
        else if (cmd_period_min > START_P) clamped = START_P;
        else                               clamped = cmd_period_min;
    end

    // Interval for the step about to start; rem (before decrement) is that step's steps-left count.
    always_comb begin
        cur_nxt  = cur;
        ramp_nxt = ramp_cnt;
        cur_up   = {1'b0, cur} + {1'b0, ACC};
        if (setup_end) begin
            cur_nxt  = START_P;
            ramp_nxt = '0;
        end else if (rem - 16'd1 <= ramp_cnt) begin
            cur_nxt  = (cur_up > {1'b0, START_P}) ? START_P : cur_up[15:0];
            ramp_nxt = (ramp_cnt == '0) ? '0 : ramp_cnt - 16'd1;
        end else if (cur > period_min) begin
            cur_nxt  = (cur - period_min >= ACC) ? cur - ACC : period_min;
            ramp_nxt = (ramp_cnt == '1) ? '1 : ramp_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick          <= '0;
            rem           <= '0;
            cur           <= '0;
            ramp_cnt      <= '0;
            period_min    <= '0;
            abort_seen    <= 1'b0;
            rotate_pulse  <= 1'b0;
            direction     <= 1'b0;
            module_enable <= 1'b0;
            done          <= 1'b0;
            position      <= '0;
        end else begin
            done <= 1'b0;
            tick <= tick + 16'd1;
            if (accept) begin
                if (cmd_steps == '0) begin
                    done <= 1'b1;
                end else begin
                    rem           <= cmd_steps;
                    period_min    <= clamped;
                    direction     <= cmd_dir;
                    module_enable <= 1'b1;
                    abort_seen    <= 1'b0;
                    tick          <= '0;
                end
            end
            if (state == RUN && abort) abort_seen <= 1'b1;
            if (step_start) begin
                rotate_pulse <= 1'b1;
                tick         <= 16'd1;
                rem          <= rem - 16'd1;
                cur          <= cur_nxt;
                ramp_cnt     <= ramp_nxt;
                position     <= direction ? position + 32'sd1 : position - 32'sd1;
            end else if (state == RUN && tick == PW) begin
                rotate_pulse <= 1'b0;
            end
            if (run_stop) tick <= '0;
            if (hold_end) begin
                module_enable <= 1'b0;
                done          <= 1'b1;
                tick          <= '0;
            end
        end
    end

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Scoreboard bench for stepper_move_ctrl: expected pulses/done events are queued when a
// command is issued and checked by a negedge monitor as the DUT produces them.
module tb_stepper_move_ctrl;

    localparam int START_PERIOD = 100;
    localparam int MIN_PERIOD   = 20;
    localparam int ACCEL_DEC    = 10;
    localparam int PULSE_WIDTH  = 8;
    localparam int DIR_SETUP    = 16;
    localparam int HOLD_CYCLES  = 1000;

    logic clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, cmd_dir = 1'b0, abort = 1'b0;
    logic [15:0] cmd_steps = '0, cmd_period_min = '0;
    logic cmd_ready, rotate_pulse, direction, module_enable, busy, done;
    logic signed [31:0] position;

    always #5 clk = ~clk;

    stepper_move_ctrl #(
        .START_PERIOD(START_PERIOD), .MIN_PERIOD(MIN_PERIOD), .ACCEL_DEC(ACCEL_DEC),
        .PULSE_WIDTH(PULSE_WIDTH), .DIR_SETUP(DIR_SETUP), .HOLD_CYCLES(HOLD_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_period_min(cmd_period_min),
        .abort(abort), .rotate_pulse(rotate_pulse), .direction(direction),
        .module_enable(module_enable), .busy(busy), .done(done), .position(position)
    );

    typedef struct { int gap; int pos; bit dir; } pulse_t;
    typedef struct { bit zero; int t; int pos; } done_t;

    pulse_t pq[$];
    done_t  dq[$];
    int n_checks = 0, n_fail = 0;
    int cyc = 0, exp_pos = 0, rises = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor
    logic prev_pulse = 1'b0, prev_busy = 1'b0, first = 1'b0;
    int acc_cyc = 0, last_rise = 0;
    pulse_t pe;
    done_t  de;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_pulse = 1'b0;
            prev_busy  = 1'b0;
            first      = 1'b0;
        end else begin
            if (busy && !prev_busy) begin
                acc_cyc = cyc;
                first   = 1'b1;
            end
            if (rotate_pulse && !prev_pulse) begin
                rises++;
                if (pq.size() == 0) begin
                    check_eq("extra_pulse", 1, 0);
                end else begin
                    pe = pq.pop_front();
                    check_eq("pulse_gap", first ? cyc - acc_cyc : cyc - last_rise, pe.gap);
                    check_eq("pulse_pos", position, pe.pos);
                    check_eq("pulse_dir", direction, pe.dir);
                    check_eq("pulse_enable", module_enable, 1);
                end
                first     = 1'b0;
                last_rise = cyc;
            end
            if (!rotate_pulse && prev_pulse)
                check_eq("pulse_width", cyc - last_rise, PULSE_WIDTH);
            if (done) begin
                if (dq.size() == 0) begin
                    check_eq("extra_done", 1, 0);
                end else begin
                    de = dq.pop_front();
                    check_eq("done_time", de.zero ? cyc : cyc - last_rise, de.t);
                    check_eq("done_pos", position, de.pos);
                    check_eq("done_enable", module_enable, 0);
                    check_eq("done_ready", cmd_ready, 1);
                end
            end
            prev_pulse = rotate_pulse;
            prev_busy  = busy;
        end
    end

    // Reference ramp: computes each step's spacing from the previous pulse and the final interval.
    task automatic push_model(input int steps, input bit dir, input int pmin, input int n_issue);
        int pm, cur, rc, prev, rem;
        pm  = (pmin < MIN_PERIOD) ? MIN_PERIOD : (pmin > START_PERIOD) ? START_PERIOD : pmin;
        cur = START_PERIOD;
        rc  = 0;
        prev = 0;
        for (int k = 1; k <= n_issue; k++) begin
            if (k > 1) begin
                rem  = steps - k + 1;
                prev = cur;
                if (rem - 1 <= rc) begin
                    cur = (cur + ACCEL_DEC > START_PERIOD) ? START_PERIOD : cur + ACCEL_DEC;
                    if (rc > 0) rc--;
                end else if (cur > pm) begin
                    cur = (cur - ACCEL_DEC < pm) ? pm : cur - ACCEL_DEC;
                    rc++;
                end
            end
            exp_pos += dir ? 1 : -1;
            pq.push_back('{(k == 1) ? DIR_SETUP : prev, exp_pos, dir});
        end
        dq.push_back('{1'b0, cur + HOLD_CYCLES, exp_pos});
    endtask

    task automatic push_gap(input int gap, input bit dir);
        exp_pos += dir ? 1 : -1;
        pq.push_back('{gap, exp_pos, dir});
    endtask

    task automatic start_move(input int steps, input bit dir, input int pmin, input bit keep);
        @(negedge clk);
        cmd_steps      = 16'(steps);
        cmd_dir        = dir;
        cmd_period_min = 16'(pmin);
        cmd_valid      = 1'b1;
        @(negedge clk);
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic wait_rises(input int target);
        for (int i = 0; i < 20000 && rises < target; i++) @(negedge clk);
        if (rises < target) check_eq("wait_rises_timeout", rises, target);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20000 && (pq.size() != 0 || dq.size() != 0 || busy); i++)
            @(negedge clk);
        if (pq.size() != 0 || dq.size() != 0 || busy)
            check_eq("drain_timeout", pq.size() + dq.size(), 0);
    endtask

    int base;

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_pulse", rotate_pulse, 0);
        check_eq("rst_enable", module_enable, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_pos", position, 0);
        check_eq("rst_dir", direction, 0);
        check_eq("rst_ready", cmd_ready, 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // zero-step command: only a done pulse the cycle after accept
        cmd_steps = '0;
        cmd_dir = 1'b1;
        cmd_period_min = 16'd50;
        cmd_valid = 1'b1;
        dq.push_back('{1'b1, cyc + 1, exp_pos});
        @(negedge clk);
        cmd_valid = 1'b0;
        check_eq("zero_dir", direction, 0);
        check_eq("zero_enable", module_enable, 0);
        check_eq("zero_busy", busy, 0);
        wait_drain();

        // 6 steps forward, cruise 50: accel to 80 then decel
        push_gap(DIR_SETUP, 1);
        push_gap(100, 1);
        push_gap(90, 1);
        push_gap(80, 1);
        push_gap(90, 1);
        push_gap(100, 1);
        dq.push_back('{1'b0, 100 + HOLD_CYCLES, exp_pos});
        start_move(6, 1, 50, 0);
        wait_drain();
        check_eq("pos_after_6", position, 6);

        // 3 steps reverse, cruise at start period
        push_gap(DIR_SETUP, 0);
        push_gap(100, 0);
        push_gap(100, 0);
        dq.push_back('{1'b0, 100 + HOLD_CYCLES, exp_pos});
        start_move(3, 0, 100, 0);
        wait_drain();
        check_eq("pos_after_rev3", position, 3);

        // abort during the 4th step of a 20-step move
        base = rises;
        push_model(20, 1, 50, 4);
        start_move(20, 1, 50, 0);
        wait_rises(base + 4);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_drain();
        check_eq("abort_pulses", rises - base, 4);

        // command held valid during the move with altered fields; cruise 5 clamps to the floor
        base = rises;
        push_model(30, 1, 5, 30);
        start_move(30, 1, 5, 1);
        cmd_dir = 1'b0;
        cmd_steps = 16'd3;
        wait_rises(base + 5);
        check_eq("held_ready", cmd_ready, 0);
        check_eq("held_busy", busy, 1);
        wait_rises(base + 30);
        cmd_valid = 1'b0;
        wait_drain();
        check_eq("pos_after_held", position, exp_pos);

        // reset in the middle of a pulse
        base = rises;
        push_model(10, 1, 50, 10);
        start_move(10, 1, 50, 0);
        wait_rises(base + 3);
        check_eq("pre_reset_pulse", rotate_pulse, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("midrst_pulse", rotate_pulse, 0);
        check_eq("midrst_enable", module_enable, 0);
        check_eq("midrst_pos", position, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_done", done, 0);
        pq.delete();
        dq.delete();
        exp_pos = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("post_rst_done", done, 0);

        // short reverse move from the reset position
        push_model(2, 0, 20, 2);
        start_move(2, 0, 20, 0);
        wait_drain();
        check_eq("pos_final", position, -2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
